// File: rtl/jtldtest_pkg.sv
// jtldtest_pkg: FSM encoding and LFSR helpers shared by the SDRAM load-test core
// The LFSR step is also used by the SDRAM read-back checker to predict download data.
package jtldtest_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SEND, S_GAP, S_DRAIN, S_DONE} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? LFSR_TAPS : 16'h0);
    endfunction
endpackage

// File: rtl/jtldtest_lfsr16.sv
// jtldtest_lfsr16: 16-bit Galois LFSR with load, step and hold
// Ports: clk; rst loads seed; ld loads seed (wins over step); seed: load value;
//        step: advance one step; q: current LFSR state.
module jtldtest_lfsr16 import jtldtest_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);
    always_ff @(posedge clk)
        q <= (rst || ld) ? seed : step ? lfsr_next(q) : q;
endmodule

// File: rtl/jtldtest_dwnld_gen.sv
// jtldtest_dwnld_gen: self-test ROM download source fed by a seeded LFSR
// Ports: clk; rst (sync, active-high); start: level request to begin a download;
//        dwnld_busy: game still committing data to SDRAM;
//        downloading/ioctl_addr/ioctl_dout/ioctl_wr: ROM-loader style byte stream;
//        done: download finished and dwnld_busy dropped; sum: byte checksum mod 2^16.
module jtldtest_dwnld_gen import jtldtest_pkg::*; #(
    parameter logic [24:0] LEN  = 25'h10_0000,
    parameter int          GAP  = 7,
    parameter int          PRE  = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dwnld_busy,
    output logic        downloading,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        ioctl_wr,
    output logic        done,
    output logic [15:0] sum
);
    localparam int CW = $clog2((PRE > GAP ? PRE : GAP) + 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [24:0]   addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic [15:0]   sum_q, sum_d;
    logic [15:0]   lfsr_q, lfsr_nx;
    logic          lfsr_ld, lfsr_step;
    logic          unused_lfsr_hi;

    jtldtest_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .ld   (lfsr_ld),
        .seed (SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // The data register takes the post-step value at the same edge the LFSR steps,
    // so the byte is already on ioctl_dout during the strobe.
    assign lfsr_nx        = lfsr_next(lfsr_q);
    assign unused_lfsr_hi = ^lfsr_nx[15:8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        sum_d     = sum_q;
        lfsr_ld   = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_PRE;
                cnt_d   = '0;
                addr_d  = '0;
                sum_d   = '0;
                lfsr_ld = 1'b1;
            end
            S_PRE: if (cnt_q == CW'(PRE - 1)) begin
                state_d = S_SEND;
                cnt_d   = '0;
                dout_d  = lfsr_q[7:0];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_SEND: begin
                state_d = S_GAP;
                sum_d   = sum_q + {8'h0, dout_q};
            end
            S_GAP: if (cnt_q == CW'(GAP - 1)) begin
                cnt_d = '0;
                if (addr_q == LEN - 25'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d   = S_SEND;
                    addr_d    = addr_q + 25'd1;
                    dout_d    = lfsr_nx[7:0];
                    lfsr_step = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_DRAIN: state_d = dwnld_busy ? S_DRAIN : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            sum_q   <= sum_d;
        end
    end

    assign downloading = state_q inside {S_PRE, S_SEND, S_GAP};
    assign ioctl_wr    = state_q == S_SEND;
    assign done        = state_q == S_DONE;
    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign sum         = sum_q;
endmodule

// File: tb/tb_jtldtest_dwnld_gen.sv
// tb_jtldtest_dwnld_gen: scoreboard bench for the self-test download source
module tb_jtldtest_dwnld_gen;
    typedef struct {
        int          t;
        logic [24:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        busy  = 1'b0;
    logic [1:0]  sel   = 2'd0;
    int          cyc   = 0;
    int          nchk  = 0;
    int          nerr  = 0;
    exp_t        sb[$];
    logic [2:0]  st_v, bz_v, dl_v, wr_v, dn_v;
    logic [24:0] ad_v [3];
    logic [7:0]  dt_v [3];
    logic [15:0] sm_v [3];
    logic        dl, wr, dn;
    logic [24:0] ad;
    logic [7:0]  dt;
    logic [15:0] sm;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_sel
        assign st_v[g] = start && sel == 2'(g);
        assign bz_v[g] = busy && sel == 2'(g);
    end

    assign dl = dl_v[sel];
    assign wr = wr_v[sel];
    assign dn = dn_v[sel];
    assign ad = ad_v[sel];
    assign dt = dt_v[sel];
    assign sm = sm_v[sel];

    jtldtest_dwnld_gen #(.LEN(25'd4), .GAP(1), .PRE(2)) u_a (
        .clk(clk), .rst(rst), .start(st_v[0]), .dwnld_busy(bz_v[0]),
        .downloading(dl_v[0]), .ioctl_addr(ad_v[0]), .ioctl_dout(dt_v[0]),
        .ioctl_wr(wr_v[0]), .done(dn_v[0]), .sum(sm_v[0])
    );
    jtldtest_dwnld_gen #(.LEN(25'd1), .GAP(1), .PRE(1)) u_b (
        .clk(clk), .rst(rst), .start(st_v[1]), .dwnld_busy(bz_v[1]),
        .downloading(dl_v[1]), .ioctl_addr(ad_v[1]), .ioctl_dout(dt_v[1]),
        .ioctl_wr(wr_v[1]), .done(dn_v[1]), .sum(sm_v[1])
    );
    jtldtest_dwnld_gen #(.LEN(25'd600)) u_c (
        .clk(clk), .rst(rst), .start(st_v[2]), .dwnld_busy(bz_v[2]),
        .downloading(dl_v[2]), .ioctl_addr(ad_v[2]), .ioctl_dout(dt_v[2]),
        .ioctl_wr(wr_v[2]), .done(dn_v[2]), .sum(sm_v[2])
    );

    function automatic logic [15:0] model_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic push_exp(input int t0, input int len, input int gap, input int pre,
                            output logic [15:0] s);
        logic [15:0] lf;
        lf = 16'hACE1;
        s  = 16'h0;
        sb.delete();
        for (int i = 0; i < len; i++) begin
            sb.push_back('{t0 + 1 + pre + i * (gap + 1), 25'(i), lf[7:0]});
            s  = s + {8'h0, lf[7:0]};
            lf = model_step(lf);
        end
    endtask

    // Runs one download on the selected instance; strobes are checked against the scoreboard.
    task automatic run_dl(input int len, input int gap, input int pre, input int hold, input bit stray,
                          output int t0, output int t_fall, output int t_done, output int n_wr,
                          output logic [15:0] esum, output logic done_early);
        exp_t e;
        logic pwr, pdl;
        int   s_left, budget;
        pwr = 1'b0; pdl = 1'b0; s_left = 0;
        t_fall = -1; t_done = -1; n_wr = 0; done_early = 1'b1;
        budget = pre + len * (gap + 1) + hold + 40;
        @(negedge clk);
        t0    = cyc;
        start = 1'b1;
        busy  = hold > 0;
        push_exp(t0, len, gap, pre, esum);
        for (int k = 0; k < budget && t_done < 0; k++) begin
            @(negedge clk);
            if (k == 0) done_early = dn;
            if (wr) begin
                n_wr++;
                if (stray && n_wr == 2) s_left = 2;
                nchk += 2;
                if (!dl) begin nerr++; $display("FAIL wr_outside_window: cycle %0d", cyc); end
                if (pwr) begin nerr++; $display("FAIL wr_back_to_back: cycle %0d", cyc); end
                nchk++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL extra_strobe: cycle %0d addr %0h", cyc, ad);
                end else begin
                    e = sb.pop_front();
                    nchk += 3;
                    if (cyc !== e.t) begin nerr++; $display("FAIL strobe_time: got %0d want %0d", cyc - t0, e.t - t0); end
                    if (ad !== e.a) begin nerr++; $display("FAIL strobe_addr: got %0h want %0h", ad, e.a); end
                    if (dt !== e.d) begin nerr++; $display("FAIL strobe_data: got %0h want %0h", dt, e.d); end
                end
            end
            start = s_left > 0;
            if (s_left > 0) s_left--;
            if (pdl && !dl && t_fall < 0) t_fall = cyc;
            if (t_fall >= 0 && cyc >= t_fall + hold) busy = 1'b0;
            if (dn && t_done < 0) t_done = cyc;
            pwr = wr;
            pdl = dl;
        end
        start = 1'b0;
        busy  = 1'b0;
        nchk += 2;
        if (t_done < 0) begin nerr++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
        if (sb.size() != 0) begin nerr++; $display("FAIL missing_strobes: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            nchk++;
            if ({dl, wr, dn, ad, dt, sm} !== '0)
                begin nerr++; $display("FAIL reset_outputs[%0d]: got %0h want 0", k, {dl, wr, dn, ad, dt, sm}); end
        end
        sel = 2'd0;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd0;
        run_dl(4, 1, 2, 0, 1'b0, t0, tf, td, n, es, de);
        nchk += 6;
        if (n !== 4) begin nerr++; $display("FAIL basic_count: got %0d want 4", n); end
        if (sm !== 16'h0225) begin nerr++; $display("FAIL basic_sum: got %0h want 0225", sm); end
        if (tf !== t0 + 11) begin nerr++; $display("FAIL basic_fall: got t+%0d want t+11", tf - t0); end
        if (td !== t0 + 12) begin nerr++; $display("FAIL basic_done: got t+%0d want t+12", td - t0); end
        if (ad !== 25'd3) begin nerr++; $display("FAIL basic_addr_hold: got %0h want 3", ad); end
        if (dt !== 8'h9C) begin nerr++; $display("FAIL basic_data_hold: got %0h want 9c", dt); end
    endtask

    task automatic test_busy;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd0;
        run_dl(4, 1, 2, 20, 1'b0, t0, tf, td, n, es, de);
        nchk += 5;
        if (de !== 1'b0) begin nerr++; $display("FAIL busy_done_cleared: got %0b want 0", de); end
        if (n !== 4) begin nerr++; $display("FAIL busy_count: got %0d want 4", n); end
        if (tf !== t0 + 11) begin nerr++; $display("FAIL busy_fall: got t+%0d want t+11", tf - t0); end
        if (td !== tf + 21) begin nerr++; $display("FAIL busy_done: got fall+%0d want fall+21", td - tf); end
        if (sm !== 16'h0225) begin nerr++; $display("FAIL busy_sum: got %0h want 0225", sm); end
    endtask

    task automatic test_start_ignored;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd0;
        run_dl(4, 1, 2, 0, 1'b1, t0, tf, td, n, es, de);
        nchk += 3;
        if (n !== 4) begin nerr++; $display("FAIL stray_count: got %0d want 4", n); end
        if (sm !== 16'h0225) begin nerr++; $display("FAIL stray_sum: got %0h want 0225", sm); end
        if (td !== t0 + 12) begin nerr++; $display("FAIL stray_done: got t+%0d want t+12", td - t0); end
    endtask

    task automatic test_mid_reset;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge clk);
            if (wr) n++;
        end
        nchk++;
        if (n !== 2) begin nerr++; $display("FAIL midrst_strobes: got %0d want 2", n); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        nchk++;
        if ({dl, wr, dn, ad, dt, sm} !== '0)
            begin nerr++; $display("FAIL midrst_outputs: got %0h want 0", {dl, wr, dn, ad, dt, sm}); end
        @(negedge clk);
        nchk++;
        if ({dl, dn} !== 2'b00) begin nerr++; $display("FAIL midrst_idle: got %0b want 00", {dl, dn}); end
        run_dl(4, 1, 2, 0, 1'b0, t0, tf, td, n, es, de);
        nchk += 2;
        if (n !== 4) begin nerr++; $display("FAIL midrst_replay_count: got %0d want 4", n); end
        if (sm !== 16'h0225) begin nerr++; $display("FAIL midrst_replay_sum: got %0h want 0225", sm); end
    endtask

    task automatic test_len1;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd1;
        for (int r = 0; r < 2; r++) begin
            run_dl(1, 1, 1, 0, 1'b0, t0, tf, td, n, es, de);
            nchk += 5;
            if (de !== 1'b0) begin nerr++; $display("FAIL len1_done_clear[%0d]: got %0b want 0", r, de); end
            if (n !== 1) begin nerr++; $display("FAIL len1_count[%0d]: got %0d want 1", r, n); end
            if (sm !== 16'h00E1) begin nerr++; $display("FAIL len1_sum[%0d]: got %0h want 00e1", r, sm); end
            if (dt !== 8'hE1) begin nerr++; $display("FAIL len1_data[%0d]: got %0h want e1", r, dt); end
            if (td !== t0 + 5) begin nerr++; $display("FAIL len1_done[%0d]: got t+%0d want t+5", r, td - t0); end
        end
    endtask

    task automatic test_full;
        int t0, tf, td, n; logic [15:0] es; logic de;
        sel = 2'd2;
        run_dl(600, 7, 16, 0, 1'b0, t0, tf, td, n, es, de);
        nchk += 4;
        if (n !== 600) begin nerr++; $display("FAIL full_count: got %0d want 600", n); end
        if (sm !== es) begin nerr++; $display("FAIL full_sum: got %0h want %0h", sm, es); end
        if (tf !== t0 + 4817) begin nerr++; $display("FAIL full_fall: got t+%0d want t+4817", tf - t0); end
        if (td !== t0 + 4818) begin nerr++; $display("FAIL full_done: got t+%0d want t+4818", td - t0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_start_ignored();
        test_mid_reset();
        test_len1();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
